// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like arbiter: merges the instruction and data ports onto one master port,
// tracks up to DEPTH outstanding transactions and routes each data_ok back via an in-order tag FIFO.
module sram_like_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [STK_W-1:0] LIMIT_C = STK_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [DEPTH-1:0] tag_q;
    logic             lock_q, lock_d;
    logic             lock_src_q, lock_src_d;
    logic [STK_W-1:0] streak_q, streak_d;

    logic full;
    logic grant_data;
    logic grant_req;
    logic push;
    logic pop;
    logic head_tag;

    assign full     = (count_q == DEPTH_C);
    assign pop      = resetn && m_data_ok && (count_q != '0);
    assign head_tag = tag_q[rptr_q];

    // A held request keeps its port; otherwise data wins unless inst has waited out the streak.
    assign grant_data = lock_q ? lock_src_q
                               : (data_req && !(inst_req && (streak_q == LIMIT_C)));
    assign grant_req  = grant_data ? data_req : inst_req;

    // A completion in the same cycle frees a slot, so a full FIFO can still forward a request.
    assign m_req   = resetn && grant_req && (!full || pop);
    assign m_wr    = grant_data ? data_wr    : inst_wr;
    assign m_size  = grant_data ? data_size  : inst_size;
    assign m_addr  = grant_data ? data_addr  : inst_addr;
    assign m_wdata = grant_data ? data_wdata : inst_wdata;

    assign push = m_req && m_addr_ok;

    assign inst_addr_ok = push && !grant_data;
    assign data_addr_ok = push && grant_data;
    assign inst_data_ok = pop && !head_tag;
    assign data_data_ok = pop && head_tag;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        streak_d   = streak_q;

        if (push) wptr_d = wptr_q + PTR_W'(1);
        if (pop)  rptr_d = rptr_q + PTR_W'(1);

        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        if (push) begin
            lock_d = 1'b0;
        end else if (m_req) begin
            lock_d     = 1'b1;
            lock_src_d = grant_data;
        end

        if (!inst_req || (push && !grant_data)) begin
            streak_d = '0;
        end else if (push && grant_data && (streak_q != LIMIT_C)) begin
            streak_d = streak_q + STK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
            streak_q   <= '0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            streak_q   <= streak_d;
        end
    end

    // Tag storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push) tag_q[wptr_q] <= grant_data;
    end

endmodule
